atan2_vectoring: RTL and testbench



---
 rtl/atan2_vectoring.sv | 161 ++++++++++++++++
 tb/tb_atan2_vectoring.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atan2_vectoring.sv
// atan2_vectoring: iterative CORDIC, vectoring mode.
// Rotates (X, Y) onto the +x axis and accumulates the rotation angle, which
// gives atan2(Y, X) as a 16-bit binary angle (0x10000 = 360 deg) together with
// the gain-compensated vector length.
//
// Ports
//   Clk_i    clock, rising edge
//   Rst_i    asynchronous reset, active low
//   X_i/Y_i  signed Q1.14 vector components
//   Start_i  request, only looked at in IDLE or DONE
//   Angle_o  binary angle 0x0000..0xFFFF
//   Mag_o    unsigned Q1.14 magnitude
//   Busy_o   computation in progress
//   Done_o   result valid, held until the next accepted Start_i
//
// Latency: Done_o rises on the (ITER+2)th edge after the edge sampling
// Start_i (ITER+3 edges counting the sampling edge). ITER is legal in 8..16.
module atan2_vectoring #(
  parameter int ITER = 14
) (
  input  logic        Clk_i,
  input  logic        Rst_i,
  input  logic [15:0] X_i,
  input  logic [15:0] Y_i,
  input  logic        Start_i,
  output logic [15:0] Angle_o,
  output logic [15:0] Mag_o,
  output logic        Busy_o,
  output logic        Done_o
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_SCALE, S_DONE} state_t;

  localparam logic [3:0] LAST = 4'(ITER - 1);

  state_t             state, state_nxt;
  logic signed [17:0] x, y;
  logic signed [17:0] xs, ys;
  logic        [15:0] z;
  logic        [3:0]  i;
  logic               zero;
  logic signed [35:0] xw, prod;
  logic signed [20:0] mag_full;
  logic        [15:0] mag_sat;

  function automatic logic [15:0] atan_lut(input logic [3:0] k);
    case (k)
      4'd0:    atan_lut = 16'h2000;
      4'd1:    atan_lut = 16'h12E4;
      4'd2:    atan_lut = 16'h09FB;
      4'd3:    atan_lut = 16'h0511;
      4'd4:    atan_lut = 16'h028B;
      4'd5:    atan_lut = 16'h0146;
      4'd6:    atan_lut = 16'h00A3;
      4'd7:    atan_lut = 16'h0051;
      4'd8:    atan_lut = 16'h0029;
      4'd9:    atan_lut = 16'h0014;
      4'd10:   atan_lut = 16'h000A;
      4'd11:   atan_lut = 16'h0005;
      4'd12:   atan_lut = 16'h0003;
      4'd13:   atan_lut = 16'h0001;
      4'd14:   atan_lut = 16'h0001;
      default: atan_lut = 16'h0000;
    endcase
  endfunction

  // State register
  always_ff @(posedge Clk_i or negedge Rst_i)
    if (!Rst_i) state <= S_IDLE;
    else        state <= state_nxt;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (Start_i) state_nxt = S_PRE;
      S_PRE:          state_nxt = S_ITER;
      S_ITER:         if (i == LAST) state_nxt = S_SCALE;
      S_SCALE:        state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Status outputs follow the state register directly, so reset clears them
  // and an accepted Start drops Done_o on the same edge it raises Busy_o.
  always_comb begin
    Busy_o = (state == S_PRE) || (state == S_ITER) || (state == S_SCALE);
    Done_o = (state == S_DONE);
  end

  // Micro-rotation shifts use the pre-update x and y.
  assign xs = x >>> i;
  assign ys = y >>> i;

  // Gain compensation: x * (1/K in Q0.15) >> 15. After convergence x is never
  // negative; clamp anyway and saturate the top end to 16 bits unsigned.
  assign xw       = 36'(x);
  assign prod     = xw * 36'sd19898;
  assign mag_full = 21'(prod >>> 15);

  always_comb begin
    if (mag_full[20])         mag_sat = 16'h0000;
    else if (|mag_full[19:16]) mag_sat = 16'hFFFF;
    else                      mag_sat = mag_full[15:0];
  end

  // Datapath. 18-bit x/y leave room for negating -32768 and for the ~1.65x
  // CORDIC growth of a full-scale diagonal vector.
  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      x       <= '0;
      y       <= '0;
      z       <= '0;
      i       <= '0;
      zero    <= 1'b0;
      Angle_o <= '0;
      Mag_o   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Start_i) begin
            x <= {{2{X_i[15]}}, X_i};
            y <= {{2{Y_i[15]}}, Y_i};
          end
        end
        S_PRE: begin
          i    <= '0;
          // The null vector would otherwise converge to an arbitrary angle.
          zero <= (x == '0) && (y == '0);
          // Left half-plane: rotate by 180 deg so the iterations only have
          // to cover +-90 deg.
          if (x < 0) begin
            x <= -x;
            y <= -y;
            z <= 16'h8000;
          end else begin
            z <= 16'h0000;
          end
        end
        S_ITER: begin
          if (!y[17]) begin
            x <= x + ys;
            y <= y - xs;
            z <= z + atan_lut(i);
          end else begin
            x <= x - ys;
            y <= y + xs;
            z <= z - atan_lut(i);
          end
          i <= i + 4'd1;
        end
        S_SCALE: begin
          Angle_o <= zero ? 16'h0000 : z;
          Mag_o   <= zero ? 16'h0000 : mag_sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atan2_vectoring.sv
// Self-checking bench for atan2_vectoring. Expected angles and magnitudes come
// from real-valued atan2/sqrt, from literal constants, or from the angle used
// to synthesise a unit vector (loopback).
module tb_atan2_vectoring;

  localparam int  ITER = 14;
  // Edges after the Start-sampling edge until Done_o is high.
  localparam int  LAT  = ITER + 2;
  localparam real PI   = 3.14159265358979;

  logic        Clk_i = 1'b0;
  logic        Rst_i = 1'b0;
  logic [15:0] X_i = '0, Y_i = '0;
  logic        Start_i = 1'b0;
  logic [15:0] Angle_o, Mag_o;
  logic        Busy_o, Done_o;

  int checks = 0;
  int failures = 0;

  atan2_vectoring #(.ITER(ITER)) dut (
    .Clk_i(Clk_i), .Rst_i(Rst_i), .X_i(X_i), .Y_i(Y_i), .Start_i(Start_i),
    .Angle_o(Angle_o), .Mag_o(Mag_o), .Busy_o(Busy_o), .Done_o(Done_o)
  );

  always #5 Clk_i = ~Clk_i;

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  // Circular distance between two binary angles.
  function automatic int adiff(input int a, input int b);
    int d;
    d = (a - b) & 32'hFFFF;
    return (d > 32767) ? 65536 - d : d;
  endfunction

  function automatic int ideal_angle(input logic [15:0] xv, input logic [15:0] yv);
    real a;
    a = $atan2(real'($signed(yv)), real'($signed(xv))) * 65536.0 / (2.0 * PI);
    if (a < 0.0) a = a + 65536.0;
    return rnd(a) & 32'hFFFF;
  endfunction

  function automatic int ideal_mag(input logic [15:0] xv, input logic [15:0] yv);
    real xr, yr;
    xr = real'($signed(xv));
    yr = real'($signed(yv));
    return rnd($sqrt(xr * xr + yr * yr));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Stimulus only: issue one Start pulse and wait (bounded) for Done_o.
  task automatic run(input logic [15:0] xv, input logic [15:0] yv,
                     output int lat, output logic [15:0] ang, output logic [15:0] mag);
    @(posedge Clk_i); #1;
    X_i = xv; Y_i = yv; Start_i = 1'b1;
    @(posedge Clk_i); #1;
    Start_i = 1'b0;
    lat = 0;
    while (!Done_o && lat < 100) begin
      @(posedge Clk_i); #1;
      lat++;
    end
    ang = Angle_o;
    mag = Mag_o;
  endtask

  task automatic test_reset;
    @(negedge Clk_i);
    checks++;
    if ({Angle_o, Mag_o, Busy_o, Done_o} !== 34'd0) begin
      failures++;
      $display("FAIL reset_hold: ang=%h mag=%h busy=%b done=%b, want all 0",
               Angle_o, Mag_o, Busy_o, Done_o);
    end
    repeat (2) @(posedge Clk_i);
    #1 Rst_i = 1'b1;
    repeat (3) @(posedge Clk_i);
    #1;
    checks++;
    if ({Angle_o, Mag_o, Busy_o, Done_o} !== 34'd0) begin
      failures++;
      $display("FAIL reset_release: ang=%h mag=%h busy=%b done=%b, want all 0 idle",
               Angle_o, Mag_o, Busy_o, Done_o);
    end
  endtask

  task automatic test_axes;
    logic [15:0] tx[6], ty[6], ta[6], tm[6];
    int lat;
    logic [15:0] ang, mag;
    tx = '{16'h4000, 16'h4000, 16'h0000, 16'hC000, 16'h0000, 16'h8000};
    ty = '{16'h4000, 16'h0000, 16'h4000, 16'h0000, 16'hC000, 16'h0000};
    ta = '{16'h2000, 16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h8000};
    tm = '{16'h5A82, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h8000};
    for (int k = 0; k < 6; k++) begin
      run(tx[k], ty[k], lat, ang, mag);
      checks++;
      if (lat !== LAT) begin
        failures++;
        $display("FAIL axes_latency[%0d]: got %0d edges, want %0d", k, lat, LAT);
      end
      checks++;
      if (adiff(int'(ang), int'(ta[k])) > 2) begin
        failures++;
        $display("FAIL axes_angle[%0d]: got %h, want %h +-2", k, ang, ta[k]);
      end
      checks++;
      if (iabs(int'(mag) - int'(tm[k])) > 4) begin
        failures++;
        $display("FAIL axes_mag[%0d]: got %h, want %h +-4", k, mag, tm[k]);
      end
    end
  endtask

  task automatic test_zero;
    int lat;
    logic [15:0] ang, mag;
    run(16'h0000, 16'h0000, lat, ang, mag);
    checks++;
    if (lat !== LAT || ang !== 16'h0000 || mag !== 16'h0000) begin
      failures++;
      $display("FAIL zero_vector: lat=%0d ang=%h mag=%h, want lat=%0d ang=0000 mag=0000",
               lat, ang, mag, LAT);
    end
  endtask

  task automatic test_busy_start;
    logic [15:0] ax, ay, ang, mag;
    int rises, first;
    logic prev;
    ax = 16'h3000; ay = 16'h1000;
    rises = 0; first = 0; prev = 1'b0; ang = '0; mag = '0;
    @(posedge Clk_i); #1;
    X_i = ax; Y_i = ay; Start_i = 1'b1;
    @(posedge Clk_i); #1;
    Start_i = 1'b0;
    for (int c = 1; c <= LAT + 10; c++) begin
      @(posedge Clk_i); #1;
      if (Done_o && !prev) begin
        rises++;
        if (first == 0) begin
          first = c; ang = Angle_o; mag = Mag_o;
        end
      end
      prev = Done_o;
      if (c == 3) begin
        X_i = 16'hC000; Y_i = 16'hE000; Start_i = 1'b1;
      end
      if (c == 4) Start_i = 1'b0;
    end
    checks++;
    if (rises !== 1 || first !== LAT) begin
      failures++;
      $display("FAIL busy_done_once: rises=%0d first=%0d, want 1 at %0d", rises, first, LAT);
    end
    checks++;
    if (adiff(int'(ang), ideal_angle(ax, ay)) > 2 || iabs(int'(mag) - ideal_mag(ax, ay)) > 4) begin
      failures++;
      $display("FAIL busy_result: ang=%h mag=%h, want %h/%h", ang, mag,
               ideal_angle(ax, ay), ideal_mag(ax, ay));
    end
  endtask

  // Start held on the edge that enters DONE must not restart the block.
  task automatic test_start_at_done;
    logic [15:0] ang;
    @(posedge Clk_i); #1;
    X_i = 16'h2000; Y_i = 16'h3000; Start_i = 1'b1;
    @(posedge Clk_i); #1;
    Start_i = 1'b0;
    for (int c = 1; c < LAT; c++) begin
      @(posedge Clk_i); #1;
    end
    X_i = 16'h0000; Y_i = 16'h4000; Start_i = 1'b1;
    @(posedge Clk_i); #1;
    Start_i = 1'b0;
    ang = Angle_o;
    checks++;
    if (Done_o !== 1'b1 || Busy_o !== 1'b0) begin
      failures++;
      $display("FAIL start_at_done_edge: done=%b busy=%b, want 1/0", Done_o, Busy_o);
    end
    @(posedge Clk_i); #1;
    checks++;
    if (Done_o !== 1'b1 || Busy_o !== 1'b0 || Angle_o !== ang) begin
      failures++;
      $display("FAIL start_at_done_hold: done=%b busy=%b ang=%h, want 1/0/%h",
               Done_o, Busy_o, Angle_o, ang);
    end
  endtask

  // Random vectors, radius 8192..30000, issued back to back.
  task automatic test_back_to_back;
    int lat, r;
    real th;
    logic [15:0] xv, yv, ang, mag;
    for (int k = 0; k < 8; k++) begin
      r  = int'($urandom_range(8192, 30000));
      th = real'($urandom_range(0, 65535)) * 2.0 * PI / 65536.0;
      xv = 16'(rnd(real'(r) * $cos(th)));
      yv = 16'(rnd(real'(r) * $sin(th)));
      run(xv, yv, lat, ang, mag);
      checks++;
      if (lat !== LAT || adiff(int'(ang), ideal_angle(xv, yv)) > 3 ||
          iabs(int'(mag) - ideal_mag(xv, yv)) > 4) begin
        failures++;
        $display("FAIL random_vec[%0d] x=%h y=%h: lat=%0d ang=%h mag=%h, want %0d %h %h",
                 k, xv, yv, lat, ang, mag, LAT, ideal_angle(xv, yv), ideal_mag(xv, yv));
      end
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    dones = 0;
    @(posedge Clk_i); #1;
    X_i = 16'h1234; Y_i = 16'h2345; Start_i = 1'b1;
    @(posedge Clk_i); #1;
    Start_i = 1'b0;
    repeat (6) @(posedge Clk_i);
    #2 Rst_i = 1'b0;
    #1;
    checks++;
    if ({Angle_o, Mag_o, Busy_o, Done_o} !== 34'd0) begin
      failures++;
      $display("FAIL reset_mid_async: ang=%h mag=%h busy=%b done=%b, want all 0",
               Angle_o, Mag_o, Busy_o, Done_o);
    end
    repeat (2) @(posedge Clk_i);
    @(negedge Clk_i) Rst_i = 1'b1;
    for (int c = 0; c < LAT + 6; c++) begin
      @(posedge Clk_i); #1;
      if (Done_o || Busy_o) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_done: busy/done seen %0d cycles, want 0", dones);
    end
  endtask

  // Unit vectors made from a known angle (as a sine/cosine block would) must
  // come back to that angle.
  task automatic test_loopback;
    int lat, a;
    real th;
    logic [15:0] xv, yv, ang, mag;
    for (int k = 0; k < 32; k++) begin
      a  = int'($urandom_range(0, 65535));
      th = real'(a) * 2.0 * PI / 65536.0;
      xv = 16'(rnd(16384.0 * $cos(th)));
      yv = 16'(rnd(16384.0 * $sin(th)));
      run(xv, yv, lat, ang, mag);
      checks++;
      if (lat !== LAT || adiff(int'(ang), a) > 3) begin
        failures++;
        $display("FAIL loopback[%0d] angle: got %h lat=%0d, want %h +-3 lat=%0d",
                 k, ang, lat, a[15:0], LAT);
      end
      checks++;
      if (iabs(int'(mag) - 16384) > 4) begin
        failures++;
        $display("FAIL loopback[%0d] mag: got %h, want 4000 +-4", k, mag);
      end
    end
  endtask

  initial begin
    test_reset;
    test_axes;
    test_zero;
    test_busy_start;
    test_start_at_done;
    test_back_to_back;
    test_reset_mid;
    test_loopback;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
